fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the pipeline.
- Owns the architectural fetch PC register and drives the instruction-bus request/response handshake.
- Redirects the PC on resolved branch/jump targets from execute, including redirects that arrive while a bus transaction is in flight.
- Presents one fetched instruction at a time to the fetch/decode pipeline register, holding it while decode stalls.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  execute resolved a taken branch, JAL or JALR this cycle.
- redirect_pc  in  64  redirect target; used as-is, alignment is checked downstream.
- stall  in  1  decode cannot accept the presented instruction this cycle.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  64  request address.
- iresp_addr_ok  in  1  bus accepted the request this cycle.
- iresp_data_ok  in  1  response data valid this cycle.
- iresp_data  in  32  instruction word; valid only when iresp_data_ok=1.
- f_valid  out  1  f_pc/f_inst hold a live instruction.
- f_pc  out  64  PC of the presented instruction.
- f_inst  out  32  presented instruction.

Behaviour:
- Registers:
  - pc: reset RESET_PC.
  - state: reset S_IDLE.
  - kill: reset 0.
  - f_valid, f_pc, f_inst: all reset 0.
- Outputs:
  - ireq_valid = (state==S_REQ), so it is 0 while reset is asserted.
  - ireq_addr = pc.
- Bus rule: once ireq_valid rises, ireq_valid and ireq_addr hold stable until the cycle iresp_addr_ok=1. Exactly one response (iresp_data_ok) follows each accepted request, no earlier than the cycle after acceptance.
- Redirect priority: redirect_valid outranks stall and iresp_data_ok in every state. The latest redirect_pc wins when several arrive before the PC is used.
- State S_IDLE: go to S_REQ on the first clock after reset deasserts.
- State S_REQ:
  - redirect without addr_ok: pc is not changed (address must stay stable). Record the target in pend_pc, set kill=1, stay in S_REQ.
  - addr_ok=1: go to S_DRAIN if kill=1 or redirect_valid=1; otherwise go to S_WAIT.
  - redirect with addr_ok in the same cycle: record pend_pc, go to S_DRAIN.
- State S_WAIT:
  - data_ok=1 with no redirect: f_inst<=iresp_data, f_pc<=pc, f_valid<=1, go to S_HOLD.
  - data_ok=1 with redirect: discard the data, pc<=redirect_pc, go to S_REQ.
  - redirect without data_ok: pend_pc<=redirect_pc, go to S_DRAIN.
- State S_DRAIN:
  - Waits for data_ok and discards the response; f_valid stays 0.
  - A redirect in this state updates pend_pc.
  - On data_ok: pc<=pend_pc, or redirect_pc if a redirect arrives that same cycle; kill<=0; go to S_REQ.
- State S_HOLD (f_valid=1):
  - redirect: f_valid<=0, pc<=redirect_pc, go to S_REQ.
  - stall=0: instruction consumed; f_valid<=0, pc<=pc+4, go to S_REQ.
  - stall=1: hold f_pc/f_inst/f_valid unchanged.
- Arithmetic: pc+4 is 64-bit modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Latency with no stall/redirect and a 1-cycle bus: one instruction per 3 cycles (REQ, WAIT, HOLD). f_valid asserts the cycle after data_ok.
- Reset mid-transaction: everything returns to its reset value immediately. The bus is reset by the same signal, so no drain is required.

Test Plan:
- Reset deasserted, bus returns addr_ok with the request and data_ok one cycle later, stall=0 -> ireq_addr sequence 8000_0000, 8000_0004, 8000_0008; f_valid pulses with f_pc matching; ireq_valid=0 during reset and in the first cycle after.
- In S_HOLD, stall=1 for 5 cycles -> f_pc/f_inst stable, no new request; stall drops -> next ireq_addr = f_pc+4.
- Redirect to 8000_0100 in S_WAIT, data_ok 2 cycles later with 0xDEADBEEF -> data discarded (f_valid stays 0); next ireq_addr=8000_0100.
- Redirects to 8000_0200 then 8000_0300 while S_REQ waits for addr_ok (held low 4 cycles) -> ireq_addr stays at the original PC until accepted; that response is dropped; next request goes to 8000_0300.
- Redirect to 8000_0040 together with stall=1 in S_HOLD -> f_valid 0 next cycle; next ireq_addr=8000_0040.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch consumed -> next ireq_addr=0. Async reset asserted mid S_WAIT -> state S_IDLE, f_valid=0, pc=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, runs the instruction-bus handshake,
// absorbs execute redirects (even mid-transaction) and presents one instruction to decode.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_inst
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] pend_pc, pend_pc_nxt;
  logic        kill, kill_nxt;
  logic        f_valid_nxt;
  logic [63:0] f_pc_nxt;
  logic [31:0] f_inst_nxt;

  assign ireq_valid = (state == S_REQ);
  assign ireq_addr  = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      kill    <= 1'b0;
      f_valid <= 1'b0;
      f_pc    <= '0;
      f_inst  <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      kill    <= kill_nxt;
      f_valid <= f_valid_nxt;
      f_pc    <= f_pc_nxt;
      f_inst  <= f_inst_nxt;
    end
  end

  // A request already on the bus cannot be retargeted, so a redirect is parked in
  // pend_pc and the matching response is drained before the new target is fetched.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    kill_nxt    = kill;
    f_valid_nxt = f_valid;
    f_pc_nxt    = f_pc;
    f_inst_nxt  = f_inst;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid) pend_pc_nxt = redirect_pc;
        if (iresp_addr_ok) begin
          state_nxt = (kill || redirect_valid) ? S_DRAIN : S_WAIT;
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (iresp_data_ok && redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (iresp_data_ok) begin
          f_inst_nxt  = iresp_data;
          f_pc_nxt    = pc;
          f_valid_nxt = 1'b1;
          state_nxt   = S_HOLD;
        end else if (redirect_valid) begin
          pend_pc_nxt = redirect_pc;
          state_nxt   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (iresp_data_ok) begin
          pc_nxt    = redirect_valid ? redirect_pc : pend_pc;
          kill_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          pend_pc_nxt = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          f_valid_nxt = 1'b0;
          pc_nxt      = redirect_pc;
          state_nxt   = S_REQ;
        end else if (!stall) begin
          f_valid_nxt = 1'b0;
          pc_nxt      = pc + 64'd4;
          state_nxt   = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
